reflet_bus_arbiter: RTL and testbench

Two-master arbiter that shares one synchronous memory/peripheral bus, with the same one-cycle read latency as the MCU's ROM/RAM/peripheral map, between the reflet CPU (master 0) and a secondary master such as a DMA or UART loader (master 1). It owns the bus mux and registered grants, and routes read data back to the master that issued the access. An optional hold timeout prevents either master from starving the other.

---
 rtl/reflet_bus_arbiter_pkg.sv | 18 +
 rtl/reflet_arbiter_hold_counter.sv | 28 ++
 rtl/reflet_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_reflet_bus_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared definitions for the reflet two-master bus arbiter: owner encoding,
// read-return tag layout and the default hold limit.
package reflet_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_M0   = 2'b01,
        OWNER_M1   = 2'b10
    } owner_t;

    localparam int DEFAULT_MAX_HOLD = 16;

    typedef struct packed {
        logic valid;
        logic id;    // 0 = master 0, 1 = master 1
    } rd_tag_t;

endpackage

// File: rtl/reflet_arbiter_hold_counter.sv
// Counts cycles an owner holds the bus while the other master waits and flags
// when the hold limit is reached. Only used in the REFLET_ARBITER_TIMEOUT_EN build.
module reflet_arbiter_hold_counter #(
    parameter int max_hold = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic timeout
);

    logic [7:0] hold;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hold <= 8'd0;
        end else if (count_en) begin
            hold <= hold + 8'd1;
        end else begin
            hold <= 8'd0;
        end
    end

    // Fires on the last permitted cycle so the transfer lands on the next edge.
    assign timeout = count_en && (hold == 8'(max_hold - 1));

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Two-master arbiter for the shared one-cycle-latency bus: registered owner,
// bus mux and tagged read return. Optional hold timeout: REFLET_ARBITER_TIMEOUT_EN.
module reflet_bus_arbiter
    import reflet_bus_arbiter_pkg::*;
#(
    parameter int wordsize = 16,
    parameter int max_hold = DEFAULT_MAX_HOLD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m1_req,
    input  logic [wordsize-1:0] m0_addr,
    input  logic [wordsize-1:0] m1_addr,
    input  logic [wordsize-1:0] m0_wdata,
    input  logic [wordsize-1:0] m1_wdata,
    input  logic                m0_write_en,
    input  logic                m1_write_en,
    output logic                m0_grant,
    output logic                m1_grant,
    output logic [wordsize-1:0] m0_rdata,
    output logic [wordsize-1:0] m1_rdata,
    output logic                m0_rvalid,
    output logic                m1_rvalid,
    output logic                bus_enable,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_wdata,
    output logic                bus_write_en,
    input  logic [wordsize-1:0] bus_rdata
);

    owner_t  owner;
    owner_t  next_owner;
    owner_t  last_owner;
    rd_tag_t rd_tag;
    logic    owner_req;
    logic    access;
    logic    grant_change;
    logic    timeout;

    assign owner_req = (owner == OWNER_M0) ? m0_req :
                       (owner == OWNER_M1) ? m1_req : 1'b0;
    assign access    = owner_req && !reset;

    always_comb begin
        next_owner = owner;
        unique case (owner)
            OWNER_NONE: begin
                if (m0_req && m1_req) begin
                    next_owner = (last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
                end else if (m0_req) begin
                    next_owner = OWNER_M0;
                end else if (m1_req) begin
                    next_owner = OWNER_M1;
                end else begin
                    next_owner = OWNER_NONE;
                end
            end
            OWNER_M0: begin
                if (!m0_req || timeout) next_owner = m1_req ? OWNER_M1 : OWNER_NONE;
            end
            OWNER_M1: begin
                if (!m1_req || timeout) next_owner = m0_req ? OWNER_M0 : OWNER_NONE;
            end
            default: next_owner = OWNER_NONE;
        endcase
    end

    assign grant_change = (next_owner != owner);

`ifdef REFLET_ARBITER_TIMEOUT_EN
    logic other_req;

    assign other_req = (owner == OWNER_M0) ? m1_req :
                       (owner == OWNER_M1) ? m0_req : 1'b0;

    reflet_arbiter_hold_counter #(
        .max_hold (max_hold)
    ) u_hold_counter (
        .clk      (clk),
        .reset    (reset),
        .count_en (owner_req && other_req),
        .clear    (grant_change),
        .timeout  (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWNER_NONE;
            last_owner <= OWNER_M1;
            rd_tag     <= '0;
        end else begin
            owner <= next_owner;
            if (grant_change && (next_owner != OWNER_NONE)) last_owner <= next_owner;
            // Tag follows the access, not the grant, so a handover edge keeps the return.
            rd_tag.valid <= access && !bus_write_en;
            rd_tag.id    <= (owner == OWNER_M1);
        end
    end

    assign m0_grant = (owner == OWNER_M0);
    assign m1_grant = (owner == OWNER_M1);

    always_comb begin
        bus_enable   = access;
        bus_addr     = '0;
        bus_wdata    = '0;
        bus_write_en = 1'b0;
        if (access && owner == OWNER_M0) begin
            bus_addr     = m0_addr;
            bus_wdata    = m0_wdata;
            bus_write_en = m0_write_en;
        end else if (access && owner == OWNER_M1) begin
            bus_addr     = m1_addr;
            bus_wdata    = m1_wdata;
            bus_write_en = m1_write_en;
        end
    end

    assign m0_rvalid = rd_tag.valid && !rd_tag.id && !reset;
    assign m1_rvalid = rd_tag.valid &&  rd_tag.id && !reset;
    assign m0_rdata  = m0_rvalid ? bus_rdata : '0;
    assign m1_rdata  = m1_rvalid ? bus_rdata : '0;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Self-checking bench for reflet_bus_arbiter: directed arbitration scenarios with a
// read-return scoreboard keyed on the cycle each read result is due.
module tb_reflet_bus_arbiter;

    localparam int W  = 16;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         m0_req, m1_req;
    logic [W-1:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic         m0_write_en, m1_write_en;
    logic         m0_grant, m1_grant;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic         m0_rvalid, m1_rvalid;
    logic         bus_enable;
    logic [W-1:0] bus_addr, bus_wdata;
    logic         bus_write_en;
    logic [W-1:0] bus_rdata = '0;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W:0]   exp_q[$];
    int           due_q[$];
    logic [W:0]   sb_item;

    reflet_bus_arbiter #(.wordsize(W), .max_hold(MH)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_write_en(m0_write_en), .m1_write_en(m1_write_en),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .bus_enable(bus_enable), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_write_en(bus_write_en), .bus_rdata(bus_rdata)
    );

    // Clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one-cycle read latency, data derived from the address
    always @(posedge clk)
        bus_rdata <= (bus_enable && !bus_write_en) ? (bus_addr ^ 16'h5A5A) : 16'hDEAD;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_m0(input logic req, input logic [W-1:0] addr, input logic [W-1:0] wdata, input logic we);
        m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_write_en = we;
    endtask

    task automatic drive_m1(input logic req, input logic [W-1:0] addr, input logic [W-1:0] wdata, input logic we);
        m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_write_en = we;
    endtask

    // Called in the cycle the read is performed; its data is due one cycle later.
    task automatic push_read(input logic id, input logic [W-1:0] addr);
        exp_q.push_back({id, addr ^ 16'h5A5A});
        due_q.push_back(cyc + 1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_m0(1'b0, '0, '0, 1'b0);
        drive_m1(1'b0, '0, '0, 1'b0);
        step();
        step();
    endtask

    // Scoreboard: read returns must appear exactly when due, on the right master only
    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            sb_item = exp_q.pop_front();
            void'(due_q.pop_front());
            if (sb_item[W]) begin
                check("m1_read_return", {m1_rvalid, m1_rdata}, {1'b1, sb_item[W-1:0]});
                check("m0_quiet", {m0_rvalid, m0_rdata}, '0);
            end else begin
                check("m0_read_return", {m0_rvalid, m0_rdata}, {1'b1, sb_item[W-1:0]});
                check("m1_quiet", {m1_rvalid, m1_rdata}, '0);
            end
        end else begin
            check("rvalid_idle", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, '0);
        end
    end

    initial begin
        // Reset state
        apply_reset();
        sample();
        check("reset_outputs", {m0_grant, m1_grant, bus_enable, bus_write_en, bus_addr, bus_wdata}, '0);

        // Single M0 read from idle
        step(); reset = 1'b0; drive_m0(1'b1, 16'h8002, '0, 1'b0);
        sample();
        check("t1_no_grant_yet", {m0_grant, m1_grant, bus_enable}, 3'b000);
        step(); push_read(1'b0, 16'h8002);
        sample();
        check("t1_grant", {m0_grant, m1_grant, bus_enable, bus_write_en}, 4'b1010);
        check("t1_bus_addr", bus_addr, 16'h8002);
        step(); drive_m0(1'b0, '0, '0, 1'b0);
        sample();
        check("t1_no_access_after_drop", {m1_grant, bus_enable, bus_addr}, '0);
        step(); sample();
        check("t1_released", {m0_grant, m1_grant}, 2'b00);

        // Tie from idle after reset: M0 first, then M1 on the next tie
        apply_reset();
        step(); reset = 1'b0;
        drive_m0(1'b1, 16'h0010, 16'h1111, 1'b1);
        drive_m1(1'b1, 16'h0020, 16'h2222, 1'b1);
        sample();
        step(); sample();
        check("t2_tie1_grants", {m0_grant, m1_grant}, 2'b10);
        check("t2_tie1_bus", {bus_enable, bus_write_en, bus_addr, bus_wdata}, {2'b11, 16'h0010, 16'h1111});
        step(); drive_m0(1'b0, '0, '0, 1'b0); drive_m1(1'b0, '0, '0, 1'b0);
        sample();
        check("t2_drop_no_access", bus_enable, 1'b0);
        step(); drive_m0(1'b1, 16'h0010, 16'h1111, 1'b1); drive_m1(1'b1, 16'h0020, 16'h2222, 1'b1);
        sample();
        check("t2_idle_between", {m0_grant, m1_grant}, 2'b00);
        step(); sample();
        check("t2_tie2_grants", {m0_grant, m1_grant}, 2'b01);
        check("t2_tie2_bus", {bus_addr, bus_wdata}, {16'h0020, 16'h2222});
        step(); drive_m0(1'b0, '0, '0, 1'b0); drive_m1(1'b0, '0, '0, 1'b0);
        sample();
        step(); sample();

        // Handover M0 -> M1 with M0's last read still returned to M0
        step(); drive_m0(1'b1, 16'h1234, '0, 1'b0);
        sample();
        step(); push_read(1'b0, 16'h1234); drive_m1(1'b1, 16'h4321, '0, 1'b0);
        sample();
        check("t3_m0_access", {m0_grant, m1_grant, bus_enable, bus_addr}, {3'b101, 16'h1234});
        step(); drive_m0(1'b0, '0, '0, 1'b0);
        sample();
        check("t3_m0_still_granted", {m0_grant, m1_grant, bus_enable}, 3'b100);
        step(); push_read(1'b1, 16'h4321);
        sample();
        check("t3_m1_granted", {m0_grant, m1_grant, bus_enable, bus_addr}, {3'b011, 16'h4321});
        step(); drive_m1(1'b0, '0, '0, 1'b0);
        sample();
        step(); sample();
        check("t3_released", {m0_grant, m1_grant}, 2'b00);

        // Single M1 write
        step(); drive_m1(1'b1, 16'hFF01, 16'h00AB, 1'b1);
        sample();
        check("t4_no_write_before_grant", bus_write_en, 1'b0);
        step(); sample();
        check("t4_write", {m1_grant, bus_enable, bus_write_en, bus_addr, bus_wdata},
              {3'b111, 16'hFF01, 16'h00AB});
        step(); drive_m1(1'b0, '0, '0, 1'b0);
        sample();
        check("t4_write_once", {bus_enable, bus_write_en}, 2'b00);
        step(); sample();

        // Both masters hold their requests high
        step(); drive_m0(1'b1, 16'h0100, '0, 1'b0); drive_m1(1'b1, 16'h0200, '0, 1'b0);
        sample();
        for (int k = 1; k <= 16; k++) begin
            logic exp_m1;
`ifdef REFLET_ARBITER_TIMEOUT_EN
            exp_m1 = logic'(((k - 1) / MH) % 2);
`else
            exp_m1 = 1'b0;
`endif
            step();
            push_read(exp_m1, exp_m1 ? 16'h0200 : 16'h0100);
            sample();
            check($sformatf("t5_grants_k%0d", k), {m0_grant, m1_grant}, {!exp_m1, exp_m1});
            check($sformatf("t5_addr_k%0d", k), bus_addr, exp_m1 ? 16'h0200 : 16'h0100);
        end
        step(); drive_m0(1'b0, '0, '0, 1'b0); drive_m1(1'b0, '0, '0, 1'b0);
        sample();
        step(); sample();
        check("t5_released", {m0_grant, m1_grant}, 2'b00);

        // Reset in the cycle after an M0 read suppresses its return
        step(); drive_m0(1'b1, 16'h3000, '0, 1'b0);
        sample();
        step(); sample();
        check("t6_read_access", {m0_grant, bus_enable, bus_addr}, {2'b11, 16'h3000});
        step(); reset = 1'b1; drive_m0(1'b0, '0, '0, 1'b0);
        sample();
        step(); reset = 1'b0;
        sample();
        check("t6_outputs_cleared", {m0_grant, m1_grant, m0_rvalid, m1_rvalid, bus_enable,
              bus_write_en, bus_addr, bus_wdata, m0_rdata, m1_rdata}, '0);
        step(); sample();

        check("sb_drain", 64'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
